uart_rx: RTL and testbench

- Serial receiver; the downstream stage of the UART transmitter on the same line.
- Samples the asynchronous SerialDataIn at OVERSAMPLE× the baud rate and recovers 8N1 frames (LSB first).
- Presents each byte on DataRx with a sticky rx_flag, cleared by an active-low clr_rx_flag, the same handshake style as the TX end-of-transmission flag.
- Feeds the MIPS peripheral/register interface.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants, FSM encodings and sizing helpers.
// Receiver parity support is enabled with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int unsigned DEF_BAUD = 9600;
  localparam int unsigned DEF_CLK  = 50000000;
  localparam int unsigned DEF_OS   = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Never returns below 1 so the result can size a vector.
  function automatic int unsigned CeilLog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned tick_div(
    input int unsigned clk_freq,
    input int unsigned baudrate,
    input int unsigned os
  );
    return clk_freq / (baudrate * os) - 1;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk pulse every TICK_DIV+1 clocks.
// Held at zero while clr is high so a bit period starts on demand.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq   = DEF_CLK,
  parameter int unsigned baudrate   = DEF_BAUD,
  parameter int unsigned OVERSAMPLE = DEF_OS
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned TICK_DIV =
    tick_div(clk_freq, baudrate, OVERSAMPLE);
  localparam int unsigned tick_bits = CeilLog2(TICK_DIV + 1);
  localparam logic [tick_bits-1:0] LAST = tick_bits'(TICK_DIV);

  logic [tick_bits-1:0] tick_cnt_q, tick_cnt_d;

  assign tick = !clr && (tick_cnt_q == LAST);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    unique case (1'b1)
      clr:     tick_cnt_d = '0;
      tick:    tick_cnt_d = '0;
      default: tick_cnt_d = tick_cnt_q + 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with sticky flags and majority vote.
// Define UART_RX_PARITY_EN to insert an even-parity bit before stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned Nbit       = 8,
  parameter int unsigned baudrate   = DEF_BAUD,
  parameter int unsigned clk_freq   = DEF_CLK,
  parameter int unsigned OVERSAMPLE = DEF_OS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            SerialDataIn,
  input  logic            clr_rx_flag,
  output logic [Nbit-1:0] DataRx,
  output logic            rx_flag,
  output logic            frame_err,
  output logic            overrun_err,
  output logic            parity_err
);

  localparam int unsigned MID = OVERSAMPLE / 2;
  localparam int unsigned SW  = CeilLog2(OVERSAMPLE);
  localparam int unsigned BW  = CeilLog2(Nbit);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_MID  = SW'(MID);
  localparam logic [SW-1:0] S_M1   = SW'(MID - 1);
  localparam logic [SW-1:0] S_M2   = SW'(MID - 2);
  localparam logic [BW-1:0] B_LAST = BW'(Nbit - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_POST = ST_PARITY;
`else
  localparam logic [2:0] ST_POST = ST_STOP;
`endif

  logic [1:0]      sync_q, sync_d;
  logic            rxs, tick, idle;
  logic [2:0]      state_q, state_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [1:0]      smp_q, smp_d;
  logic [Nbit-1:0] shift_q, shift_d;
  logic [Nbit-1:0] data_q, data_d;
  logic            arm_q, arm_d;
  logic            flag_q, flag_d;
  logic            ferr_q, ferr_d;
  logic            oerr_q, oerr_d;
  logic            vote, done, at_mid;

  assign sync_d = {sync_q[0], SerialDataIn};
  assign rxs    = sync_q[1];
  assign idle   = (state_q == ST_IDLE);

  uart_baud_tick #(
    .clk_freq  (clk_freq),
    .baudrate  (baudrate),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (idle),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    shift_d = shift_q;
    arm_d   = arm_q;
    done    = 1'b0;
    vote    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs)
            | (smp_q[1] & rxs);
    at_mid  = tick && (scnt_q == S_MID);
    if (tick) begin
      scnt_d = (scnt_q == S_LAST) ? '0 : scnt_q + 1'b1;
      if (scnt_q == S_M2) smp_d[0] = rxs;
      if (scnt_q == S_M1) smp_d[1] = rxs;
    end
    unique case (1'b1)
      state_q == ST_IDLE: begin
        scnt_d = '0;
        bit_d  = '0;
        // After a low stop bit, wait for the line to go high first.
        arm_d  = arm_q | rxs;
        if (arm_q && !rxs) state_d = ST_START;
      end
      state_q == ST_START: begin
        if (tick && scnt_q == S_M1 && rxs)
          state_d = ST_IDLE;
        else if (tick && scnt_q == S_LAST)
          state_d = ST_DATA;
      end
      state_q == ST_DATA: begin
        if (at_mid) shift_d[bit_q] = vote;
        if (tick && scnt_q == S_LAST) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == B_LAST) state_d = ST_POST;
        end
      end
`ifdef UART_RX_PARITY_EN
      state_q == ST_PARITY: begin
        if (tick && scnt_q == S_LAST) state_d = ST_STOP;
      end
`endif
      state_q == ST_STOP: begin
        if (at_mid) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          arm_d   = vote;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sets take priority over a coincident clear.
  always_comb begin
    data_d = done ? shift_q : data_q;
    flag_d = done | (flag_q & clr_rx_flag);
    ferr_d = (done & ~vote) | (ferr_q & clr_rx_flag);
    oerr_d = (done & flag_q) | (oerr_q & clr_rx_flag);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      scnt_q  <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      arm_q   <= 1'b1;
      flag_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      arm_q   <= arm_d;
      flag_q  <= flag_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, perr_q, perr_d;

  always_comb begin
    par_d = par_q;
    if (state_q == ST_PARITY && at_mid) par_d = vote ^ (^shift_q);
    perr_d = (done & par_q) | (perr_q & clr_rx_flag);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign DataRx      = data_q;
  assign rx_flag     = flag_q;
  assign frame_err   = ferr_q;
  assign overrun_err = oerr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are modelled bit-by-bit in time,
// expected bytes/flags are queued at the start edge and checked on output.
module tb_uart_rx;

  localparam int BIT = 160;
`ifdef UART_RX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int LAT     = 1525 + (FBITS - 10) * BIT;
  localparam int LAT_CLK = 1533 + (FBITS - 10) * BIT;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       SerialDataIn = 1'b1;
  logic       clr_rx_flag = 1'b1;
  logic [7:0] DataRx;
  logic       rx_flag, frame_err, overrun_err, parity_err;

  always #5 clk = ~clk;

  uart_rx #(
    .Nbit      (8),
    .baudrate  (10000),
    .clk_freq  (1600000),
    .OVERSAMPLE(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .SerialDataIn(SerialDataIn),
    .clr_rx_flag (clr_rx_flag),
    .DataRx      (DataRx),
    .rx_flag     (rx_flag),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  typedef struct {
    logic [7:0] data;
    bit         ferr;
    bit         oerr;
    bit         perr;
    int         t0;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_flag, m_ferr, m_oerr, m_perr;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_flag = 0;
    m_ferr = 0;
    m_oerr = 0;
    m_perr = 0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_rx_flag = 1'b0;
    @(negedge clk);
    clr_rx_flag = 1'b1;
    model_clear();
  endtask

  // glitch: data bit index that gets an 8-clk inverted pulse mid-bit, else none
  task automatic send(input logic [7:0] d, input bit stop, input bit par,
                      input bit clr_done, input int glitch);
    exp_t e;
    @(negedge clk);
    SerialDataIn = 1'b0;
    e.data = d;
    e.t0   = cyc;
    e.ferr = !stop | (m_ferr & !clr_done);
    e.oerr = m_flag | (m_oerr & !clr_done);
`ifdef UART_RX_PARITY_EN
    e.perr = (par != ^d) | (m_perr & !clr_done);
`else
    e.perr = 0;
`endif
    m_flag = 1;
    m_ferr = e.ferr;
    m_oerr = e.oerr;
    m_perr = e.perr;
    m_data = d;
    sb.push_back(e);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      SerialDataIn = d[i];
      if (i == glitch) begin
        repeat (76) @(negedge clk);
        SerialDataIn = ~d[i];
        repeat (8) @(negedge clk);
        SerialDataIn = d[i];
        repeat (BIT - 84) @(negedge clk);
      end else begin
        repeat (BIT) @(negedge clk);
      end
    end
`ifdef UART_RX_PARITY_EN
    SerialDataIn = par;
    repeat (BIT) @(negedge clk);
`endif
    SerialDataIn = stop;
    repeat (BIT) @(negedge clk);
    SerialDataIn = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d bytes never received", sb.size());
      sb.delete();
    end
    repeat (4) @(negedge clk);
  endtask

  // Monitor: a byte is presented when rx_flag rises, DataRx changes
  // while rx_flag is held, or overrun_err rises.
  initial begin
    logic [7:0] pd;
    logic       pf, po;
    exp_t       e;
    pd = 8'h00;
    pf = 1'b0;
    po = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && ((rx_flag && !pf) || (rx_flag && DataRx != pd) ||
                    (overrun_err && !po))) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected: byte %h with nothing sent", DataRx);
        end else begin
          e = sb.pop_front();
          chk("DataRx", DataRx, e.data);
          chk("frame_err", frame_err, e.ferr);
          chk("overrun_err", overrun_err, e.oerr);
          chk("parity_err", parity_err, e.perr);
          checks++;
          if (cyc - e.t0 < LAT - 20 || cyc - e.t0 > LAT + 20) begin
            errors++;
            $display("FAIL latency: got %0d clk, expected %0d+-20",
                     cyc - e.t0, LAT);
          end
        end
      end
      pd = DataRx;
      pf = rx_flag;
      po = overrun_err;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    model_clear();
    repeat (5) @(negedge clk);
    chk("reset DataRx", DataRx, 8'h00);
    chk("reset rx_flag", rx_flag, 1'b0);
    chk("reset frame_err", frame_err, 1'b0);
    chk("reset overrun_err", overrun_err, 1'b0);
    chk("reset parity_err", parity_err, 1'b0);
    reset = 1'b1;
    repeat (20) @(negedge clk);

    send(8'hA5, 1, ^8'hA5, 0, -1);
    wait_done();

    pulse_clr();
    SerialDataIn = 1'b0;
    repeat (50) @(negedge clk);
    SerialDataIn = 1'b1;
    repeat (300) @(negedge clk);
    chk("glitch rx_flag", rx_flag, m_flag);
    chk("glitch DataRx", DataRx, m_data);

    send(8'h3C, 0, ^8'h3C, 0, -1);
    wait_done();
    pulse_clr();
    chk("clr rx_flag", rx_flag, m_flag);
    chk("clr frame_err", frame_err, m_ferr);

    repeat (50) @(negedge clk);
    send(8'h01, 1, ^8'h01, 0, -1);
    send(8'hFF, 1, ^8'hFF, 0, -1);
    fork
      send(8'h5A, 1, ^8'h5A, 1, -1);
      begin
        @(negedge clk);
        repeat (LAT_CLK - 1) @(negedge clk);
        clr_rx_flag = 1'b0;
        @(negedge clk);
        clr_rx_flag = 1'b1;
      end
    join
    chk("clr-at-done rx_flag", rx_flag, m_flag);
    wait_done();
    pulse_clr();

    @(negedge clk);
    SerialDataIn = 1'b0;
    repeat (5 * BIT) @(negedge clk);
    reset = 1'b0;
    SerialDataIn = 1'b1;
    model_clear();
    m_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("midframe reset DataRx", DataRx, m_data);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    send(8'h55, 1, ^8'h55, 0, -1);
    wait_done();

    pulse_clr();
    send(8'h00, 0, 1'b0, 0, -1);
    SerialDataIn = 1'b0;
    repeat (500) @(negedge clk);
    SerialDataIn = 1'b1;
    wait_done();
    repeat (50) @(negedge clk);
    chk("break DataRx", DataRx, m_data);

    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(0, 1) == 1) pulse_clr();
      d = 8'($urandom);
      send(d, 1, ^d, 0, int'($urandom_range(0, 8)));
      wait_done();
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

`ifdef UART_RX_PARITY_EN
    pulse_clr();
    send(8'h07, 1, 1'b0, 0, -1);
    wait_done();
    pulse_clr();
    send(8'h07, 1, 1'b1, 0, -1);
    wait_done();
`endif

    repeat (200) @(negedge clk);
    chk("scoreboard empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
